// File: rtl/procfilt_hazard_pkg.sv
// Shared types and helpers for the REG->EXE hazard controller.
package procfilt_hazard_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned REG_W = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StBrFlush = 2'd2,
    StMcWait  = 2'd3
  } hz_state_e;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  // A matching load in EXE has no data yet; older stages hold stale values, so use the regfile.
  function automatic logic [1:0] fwd_sel(input logic exe, input logic exe_load,
                                         input logic mem, input logic wb);
    if (exe)      return exe_load ? FWD_RF : FWD_EXE;
    else if (mem) return FWD_MEM;
    else if (wb)  return FWD_WB;
    else          return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard bus: pipeline status in, stage enables/flushes and forwarding selects out.
interface pipeline_hazard_ctrl_if;
  import procfilt_hazard_pkg::*;

  logic [REG_W-1:0] i_id_Ra;
  logic [REG_W-1:0] i_id_Rb;
  logic             i_id_useA;
  logic             i_id_useB;
  logic [REG_W-1:0] i_exe_Robj;
  logic             i_exe_wr;
  logic             i_exe_load;
  logic [REG_W-1:0] i_mem_Robj;
  logic             i_mem_wr;
  logic [REG_W-1:0] i_wb_Robj;
  logic             i_wb_wr;
  logic             i_br_taken;
  logic             i_mc_start;
  logic             i_mc_done;

  logic             o_en_pc;
  logic             o_en_if_id;
  logic             o_en_reg_exe;
  logic             o_flush_if_id;
  logic             o_flush_reg_exe;
  logic [1:0]       o_fwdA;
  logic [1:0]       o_fwdB;
  logic [1:0]       o_state;
  logic             o_err;

  modport master (
    output i_id_Ra, i_id_Rb, i_id_useA, i_id_useB, i_exe_Robj, i_exe_wr, i_exe_load,
           i_mem_Robj, i_mem_wr, i_wb_Robj, i_wb_wr, i_br_taken, i_mc_start, i_mc_done,
    input  o_en_pc, o_en_if_id, o_en_reg_exe, o_flush_if_id, o_flush_reg_exe,
           o_fwdA, o_fwdB, o_state, o_err
  );

  modport slave (
    input  i_id_Ra, i_id_Rb, i_id_useA, i_id_useB, i_exe_Robj, i_exe_wr, i_exe_load,
           i_mem_Robj, i_mem_wr, i_wb_Robj, i_wb_wr, i_br_taken, i_mc_start, i_mc_done,
    output o_en_pc, o_en_if_id, o_en_reg_exe, o_flush_if_id, o_flush_reg_exe,
           o_fwdA, o_fwdB, o_state, o_err
  );

endinterface

// File: rtl/hazard_reg_match.sv
// Source/destination register comparator shared by all forwarding and load-use checks.
module hazard_reg_match
  import procfilt_hazard_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [REG_W-1:0] rx,
    input  logic             rd_en,
    input  logic [REG_W-1:0] robj,
    input  logic             wr,
    output logic             match
);

  logic rx_is_r0;

  assign rx_is_r0 = R0_ZERO && (rx == '0);
  assign match    = wr && rd_en && (robj == rx) && !rx_is_r0;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the REG->EXE pipeline register with EXE operand forwarding.
module pipeline_hazard_ctrl
  import procfilt_hazard_pkg::*;
#(
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned BR_PENALTY = 2,
    parameter int unsigned MC_TIMEOUT = 255,
    parameter bit          R0_ZERO    = 1'b1
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] LdInit  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] BrInit  = CNT_W'(BR_PENALTY - 1);
  localparam logic [CNT_W-1:0] McLimit = CNT_W'(MC_TIMEOUT);

  hz_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic exe_a, exe_b, mem_a, mem_b, wb_a, wb_b;
  logic load_use, mc_begin, mc_timeout;

  hazard_reg_match #(.R0_ZERO(R0_ZERO)) u_exe_a (
    .rx(hz.i_id_Ra), .rd_en(hz.i_id_useA), .robj(hz.i_exe_Robj), .wr(hz.i_exe_wr), .match(exe_a)
  );
  hazard_reg_match #(.R0_ZERO(R0_ZERO)) u_exe_b (
    .rx(hz.i_id_Rb), .rd_en(hz.i_id_useB), .robj(hz.i_exe_Robj), .wr(hz.i_exe_wr), .match(exe_b)
  );
  hazard_reg_match #(.R0_ZERO(R0_ZERO)) u_mem_a (
    .rx(hz.i_id_Ra), .rd_en(hz.i_id_useA), .robj(hz.i_mem_Robj), .wr(hz.i_mem_wr), .match(mem_a)
  );
  hazard_reg_match #(.R0_ZERO(R0_ZERO)) u_mem_b (
    .rx(hz.i_id_Rb), .rd_en(hz.i_id_useB), .robj(hz.i_mem_Robj), .wr(hz.i_mem_wr), .match(mem_b)
  );
  hazard_reg_match #(.R0_ZERO(R0_ZERO)) u_wb_a (
    .rx(hz.i_id_Ra), .rd_en(hz.i_id_useA), .robj(hz.i_wb_Robj), .wr(hz.i_wb_wr), .match(wb_a)
  );
  hazard_reg_match #(.R0_ZERO(R0_ZERO)) u_wb_b (
    .rx(hz.i_id_Rb), .rd_en(hz.i_id_useB), .robj(hz.i_wb_Robj), .wr(hz.i_wb_wr), .match(wb_b)
  );

  assign load_use   = hz.i_exe_load && (exe_a || exe_b);
  // A multi-cycle op that finishes in its start cycle is just a normal instruction.
  assign mc_begin   = hz.i_mc_start && !hz.i_mc_done;
  assign mc_timeout = (cnt_q == McLimit) && !hz.i_mc_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz.i_br_taken) begin
            if (BR_PENALTY > 1) begin
              state_q <= StBrFlush;
              cnt_q   <= BrInit;
            end
          end else if (mc_begin) begin
            state_q <= StMcWait;
            cnt_q   <= '0;
          end else if (load_use) begin
            if (LOAD_LAT > 1) begin
              state_q <= StLdStall;
              cnt_q   <= LdInit;
            end
          end
        end
        StLdStall, StBrFlush: begin
          if (cnt_q <= 1) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_dec(cnt_q);
          end
        end
        StMcWait: begin
          if (hz.i_mc_done) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else if (mc_timeout) begin
            state_q <= StRun;
            cnt_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc(cnt_q);
          end
        end
        default: begin
          state_q <= StRun;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  logic       en_pc, en_if_id, en_reg_exe, flush_if_id, flush_reg_exe;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    en_pc         = 1'b1;
    en_if_id      = 1'b1;
    en_reg_exe    = 1'b1;
    flush_if_id   = 1'b0;
    flush_reg_exe = 1'b0;
    fwd_a         = FWD_RF;
    fwd_b         = FWD_RF;
    if (!rst_n) begin
      en_pc         = 1'b0;
      en_if_id      = 1'b0;
      en_reg_exe    = 1'b0;
      flush_if_id   = 1'b1;
      flush_reg_exe = 1'b1;
    end else begin
      fwd_a = fwd_sel(exe_a, hz.i_exe_load, mem_a, wb_a);
      fwd_b = fwd_sel(exe_b, hz.i_exe_load, mem_b, wb_b);
      unique case (state_q)
        StRun: begin
          if (hz.i_br_taken) begin
            flush_if_id   = 1'b1;
            flush_reg_exe = 1'b1;
          end else if (mc_begin) begin
            en_pc      = 1'b0;
            en_if_id   = 1'b0;
            en_reg_exe = 1'b0;
          end else if (load_use) begin
            en_pc         = 1'b0;
            en_if_id      = 1'b0;
            flush_reg_exe = 1'b1;
          end
        end
        StLdStall: begin
          en_pc         = 1'b0;
          en_if_id      = 1'b0;
          flush_reg_exe = 1'b1;
        end
        StBrFlush: begin
          flush_if_id   = 1'b1;
          flush_reg_exe = 1'b1;
        end
        StMcWait: begin
          if (!hz.i_mc_done) begin
            en_pc         = 1'b0;
            en_if_id      = 1'b0;
            en_reg_exe    = 1'b0;
            flush_reg_exe = mc_timeout;
          end
        end
        default: ;
      endcase
    end
  end

  assign hz.o_en_pc         = en_pc;
  assign hz.o_en_if_id      = en_if_id;
  assign hz.o_en_reg_exe    = en_reg_exe;
  assign hz.o_flush_if_id   = flush_if_id;
  assign hz.o_flush_reg_exe = flush_reg_exe;
  assign hz.o_fwdA          = fwd_a;
  assign hz.o_fwdB          = fwd_b;
  assign hz.o_state         = state_q;
  assign hz.o_err           = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use, branch, multi-cycle op, reset.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();
  pipeline_hazard_ctrl_if hz2 ();

  // Second instance shares the stimulus but uses a short multi-cycle timeout.
  assign hz2.i_id_Ra    = hz.i_id_Ra;
  assign hz2.i_id_Rb    = hz.i_id_Rb;
  assign hz2.i_id_useA  = hz.i_id_useA;
  assign hz2.i_id_useB  = hz.i_id_useB;
  assign hz2.i_exe_Robj = hz.i_exe_Robj;
  assign hz2.i_exe_wr   = hz.i_exe_wr;
  assign hz2.i_exe_load = hz.i_exe_load;
  assign hz2.i_mem_Robj = hz.i_mem_Robj;
  assign hz2.i_mem_wr   = hz.i_mem_wr;
  assign hz2.i_wb_Robj  = hz.i_wb_Robj;
  assign hz2.i_wb_wr    = hz.i_wb_wr;
  assign hz2.i_br_taken = hz.i_br_taken;
  assign hz2.i_mc_start = hz.i_mc_start;
  assign hz2.i_mc_done  = hz.i_mc_done;

  pipeline_hazard_ctrl #(
    .LOAD_LAT(2), .BR_PENALTY(2), .MC_TIMEOUT(255), .R0_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz)
  );

  pipeline_hazard_ctrl #(
    .LOAD_LAT(2), .BR_PENALTY(2), .MC_TIMEOUT(4), .R0_ZERO(1'b1)
  ) dut_to (
    .clk(clk), .rst_n(rst_n), .hz(hz2)
  );

  // {en_pc, en_if_id, en_reg_exe, flush_if_id, flush_reg_exe}
  logic [4:0] ctl, ctl2;
  assign ctl  = {hz.o_en_pc, hz.o_en_if_id, hz.o_en_reg_exe, hz.o_flush_if_id,
                 hz.o_flush_reg_exe};
  assign ctl2 = {hz2.o_en_pc, hz2.o_en_if_id, hz2.o_en_reg_exe, hz2.o_flush_if_id,
                 hz2.o_flush_reg_exe};

  localparam logic [4:0] CtlReset = 5'b00011;
  localparam logic [4:0] CtlRun   = 5'b11100;
  localparam logic [4:0] CtlLdUse = 5'b00101;
  localparam logic [4:0] CtlBr    = 5'b11111;
  localparam logic [4:0] CtlHold  = 5'b00000;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.i_id_Ra = '0; hz.i_id_Rb = '0; hz.i_id_useA = 0; hz.i_id_useB = 0;
    hz.i_exe_Robj = '0; hz.i_exe_wr = 0; hz.i_exe_load = 0;
    hz.i_mem_Robj = '0; hz.i_mem_wr = 0; hz.i_wb_Robj = '0; hz.i_wb_wr = 0;
    hz.i_br_taken = 0; hz.i_mc_start = 0; hz.i_mc_done = 0;
  endtask

  task automatic set_load_hazard();
    hz.i_exe_load = 1; hz.i_exe_wr = 1; hz.i_exe_Robj = 4'd4;
    hz.i_id_Ra = 4'd4; hz.i_id_useA = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    #2;
    check("rst_ctl", 8'(ctl), 8'(CtlReset));
    check("rst_fwd", {4'h0, hz.o_fwdA, hz.o_fwdB}, 8'h00);
    check("rst_state", 8'(hz.o_state), 8'd0);
    check("rst_err", 8'(hz.o_err), 8'd0);
    cyc();
    rst_n = 1;
    #2;
    check("run_ctl", 8'(ctl), 8'(CtlRun));

    // Forwarding from EXE, MEM and WB.
    cyc();
    hz.i_exe_wr = 1; hz.i_exe_Robj = 4'd3; hz.i_id_Ra = 4'd3; hz.i_id_useA = 1;
    #2;
    check("fwd_exe", 8'(hz.o_fwdA), 8'h1);
    check("fwd_exe_ctl", 8'(ctl), 8'(CtlRun));
    hz.i_id_useA = 0;
    #1;
    check("fwd_nouse", 8'(hz.o_fwdA), 8'h0);
    cyc();
    clear_inputs();
    hz.i_mem_wr = 1; hz.i_mem_Robj = 4'd3; hz.i_id_Ra = 4'd3; hz.i_id_useA = 1;
    #2;
    check("fwd_mem", 8'(hz.o_fwdA), 8'h2);
    cyc();
    clear_inputs();
    hz.i_wb_wr = 1; hz.i_wb_Robj = 4'd3; hz.i_id_Ra = 4'd3; hz.i_id_useA = 1;
    #2;
    check("fwd_wb", 8'(hz.o_fwdA), 8'h3);

    // EXE beats MEM; register 0 never forwards.
    cyc();
    clear_inputs();
    hz.i_exe_wr = 1; hz.i_exe_Robj = 4'd5; hz.i_mem_wr = 1; hz.i_mem_Robj = 4'd5;
    hz.i_id_Rb = 4'd5; hz.i_id_useB = 1;
    #2;
    check("fwd_prio", 8'(hz.o_fwdB), 8'h1);
    cyc();
    clear_inputs();
    hz.i_exe_wr = 1; hz.i_exe_Robj = 4'd0; hz.i_id_Ra = 4'd0; hz.i_id_useA = 1;
    #2;
    check("fwd_r0", 8'(hz.o_fwdA), 8'h0);
    check("fwd_r0_ctl", 8'(ctl), 8'(CtlRun));

    // Load-use: two stall cycles then RUN.
    cyc();
    clear_inputs();
    set_load_hazard();
    #2;
    check("ld_c0_ctl", 8'(ctl), 8'(CtlLdUse));
    check("ld_c0_fwd", 8'(hz.o_fwdA), 8'h0);
    cyc();
    clear_inputs();
    #2;
    check("ld_c1_state", 8'(hz.o_state), 8'd1);
    check("ld_c1_ctl", 8'(ctl), 8'(CtlLdUse));
    cyc();
    #2;
    check("ld_end_state", 8'(hz.o_state), 8'd0);
    check("ld_end_ctl", 8'(ctl), 8'(CtlRun));

    // Branch wins over a simultaneous load-use hazard.
    cyc();
    set_load_hazard();
    hz.i_br_taken = 1;
    #2;
    check("br_c0_ctl", 8'(ctl), 8'(CtlBr));
    cyc();
    clear_inputs();
    #2;
    check("br_c1_state", 8'(hz.o_state), 8'd2);
    check("br_c1_ctl", 8'(ctl), 8'(CtlBr));
    cyc();
    #2;
    check("br_end_state", 8'(hz.o_state), 8'd0);
    check("br_end_ctl", 8'(ctl), 8'(CtlRun));

    // Multi-cycle op: ten held cycles, done on the tenth wait cycle.
    cyc();
    hz.i_mc_start = 1;
    #2;
    check("mc_start_ctl", 8'(ctl), 8'(CtlHold));
    cyc();
    hz.i_mc_start = 0;
    for (int i = 0; i < 9; i++) begin
      #2;
      check($sformatf("mc_wait%0d_ctl", i), 8'(ctl), 8'(CtlHold));
      check($sformatf("mc_wait%0d_state", i), 8'(hz.o_state), 8'd3);
      cyc();
    end
    hz.i_mc_done = 1;
    #2;
    check("mc_done_ctl", 8'(ctl), 8'(CtlRun));
    cyc();
    hz.i_mc_done = 0;
    #2;
    check("mc_end_state", 8'(hz.o_state), 8'd0);
    check("mc_end_err", 8'(hz.o_err), 8'd0);

    // Timeout on the short-timeout instance.
    rst_n = 0;
    cyc();
    rst_n = 1;
    #2;
    check("to_rst_err", 8'(hz2.o_err), 8'd0);
    cyc();
    hz.i_mc_start = 1;
    cyc();
    hz.i_mc_start = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("to_wait%0d_ctl", i), 8'(ctl2), 8'(CtlHold));
      check($sformatf("to_wait%0d_err", i), 8'(hz2.o_err), 8'd0);
      cyc();
    end
    #2;
    check("to_abort_ctl", 8'(ctl2), 8'b00001);
    check("to_abort_state", 8'(hz2.o_state), 8'd3);
    cyc();
    #2;
    check("to_err", 8'(hz2.o_err), 8'd1);
    check("to_state", 8'(hz2.o_state), 8'd0);
    check("to_ctl", 8'(ctl2), 8'(CtlRun));
    cyc();
    cyc();
    check("to_err_sticky", 8'(hz2.o_err), 8'd1);
    // Release the long-timeout instance from MC_WAIT.
    hz.i_mc_done = 1;
    cyc();
    hz.i_mc_done = 0;
    #2;
    check("mc2_state", 8'(hz.o_state), 8'd0);

    // Reset asserted during BR_FLUSH.
    cyc();
    hz.i_br_taken = 1;
    cyc();
    hz.i_br_taken = 0;
    #2;
    check("rbr_state", 8'(hz.o_state), 8'd2);
    rst_n = 0;
    #1;
    check("rbr_ctl", 8'(ctl), 8'(CtlReset));
    check("rbr_rst_state", 8'(hz.o_state), 8'd0);
    check("rbr_err_clr", 8'(hz2.o_err), 8'd0);
    cyc();
    rst_n = 1;
    cyc();
    #2;
    check("rel_state", 8'(hz.o_state), 8'd0);
    check("rel_ctl", 8'(ctl), 8'(CtlRun));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
